// File: rtl/seg_scan_driver.sv
// Scanned driver for a 4-digit common-anode seven-segment display (M.SS.T).
// Inputs are snapshotted once per frame; outputs are registered from next-state values.
module seg_scan_driver #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] minutes_bcd,
  input  logic [3:0] sec_tens_bcd,
  input  logic [3:0] sec_ones_bcd,
  input  logic [3:0] tenths_bcd,
  input  logic       flash_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = SCAN_HZ / (2 * BLINK_HZ);
  localparam int PRE_W     = $clog2(SCAN_DIV);
  localparam int BCNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(SCAN_DIV - 1);
  localparam logic [BCNT_W-1:0] BLINK_MAX = BCNT_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   shadow_q, shadow_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_start_q;
  logic              scan_tick;
  logic              capture;

  function automatic logic [6:0] decode(input logic [3:0] digit);
    case (digit)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // NOTE: every signal gets its default at the top of always_comb so no path can infer a latch.
  always_comb begin
    scan_tick = (pre_q == PRE_MAX);
    pre_d     = scan_tick ? '0 : pre_q + 1'b1;
    idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;
    capture   = scan_tick && (idx_q == 2'd3);
    shadow_d  = shadow_q;
    bcnt_d    = '0;
    phase_d   = 1'b0;

    // Snapshot on the wrap to digit 0 so a frame never mixes old and new digits.
    if (capture) begin
      shadow_d = {minutes_bcd, sec_tens_bcd, sec_ones_bcd, tenths_bcd};
    end

    if (flash_en) begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (scan_tick) begin
        if (bcnt_q == BLINK_MAX) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end

    // Drive from next-state index and shadow so the registered outputs are never a cycle stale.
    an_d  = phase_d ? 4'b1111 : ~(4'b0001 << idx_d);
    seg_d = decode(shadow_d[idx_d]);
    dp_d  = ~idx_d[0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      bcnt_q        <= '0;
      phase_q       <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      bcnt_q        <= bcnt_d;
      phase_q       <= phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= capture;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the stopwatch's 4-digit common-anode seven-segment display, formatted as M.SS.T. It sits directly downstream of the stopwatch core and consumes its BCD time digits plus a flash request. It converts them into scanned anode and cathode drive with decimal points and blinking. Inputs are captured once per frame so that a digit update from the core never tears a frame.

## Interface

**Parameters**
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `SCAN_HZ`, default 1000: digit-advance rate. `SCAN_DIV = CLK_HZ/SCAN_HZ` must be ≥ 2.
- `BLINK_HZ`, default 2: flash rate. `BLINK_DIV = SCAN_HZ/(2*BLINK_HZ)` scan ticks per half-period, must be ≥ 1.

**Ports**
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `minutes_bcd`, input, 4: minutes digit.
- `sec_tens_bcd`, input, 4: seconds tens digit.
- `sec_ones_bcd`, input, 4: seconds ones digit.
- `tenths_bcd`, input, 4: tenths digit.
- `flash_en`, input, 1: blink the whole display (countdown expired).
- `an`, output, 4: anode enables, active-low. `an[0]` is the rightmost digit.
- `seg`, output, 7: cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp`, output, 1: decimal-point cathode, active-low.
- `frame_start`, output, 1: one-cycle pulse when a new frame snapshot is taken.

## Operation

**Prescaler**
- `pre` counts 0..`SCAN_DIV`-1 and wraps.
- `scan_tick` is asserted when `pre == SCAN_DIV-1`.

**Digit index**
- `idx` is 2 bits and advances 0→1→2→3→0 on each `scan_tick`.
- idx 0 = tenths, 1 = sec_ones, 2 = sec_tens, 3 = minutes.

**Snapshot**
- All four inputs are copied into shadow registers on the `scan_tick` where `idx==3`, which is the wrap to 0.
- `frame_start` pulses on the cycle after that capture.
- Input changes mid-frame are not visible until the next frame.

**Decode** (shadow digit → `seg`)
- 0 → 1000000
- 1 → 1111001
- 2 → 0100100
- 3 → 0110000
- 4 → 0011001
- 5 → 0010010
- 6 → 0000010
- 7 → 1111000
- 8 → 0000000
- 9 → 0010000
- 10..15 (invalid BCD) → 0111111 (dash, g only)

**Decimal point**
- `dp` = 0 when idx is 1 (the point between seconds and tenths) or 3 (after minutes).
- `dp` = 1 otherwise.

**Blink**
- `bcnt` counts `scan_tick`s while `flash_en` is high.
- At `BLINK_DIV`-1 it wraps to 0 and toggles `phase`.
- When `flash_en` is low, `bcnt` and `phase` are forced to 0 (visible).
- When `phase` is 1, `an` = 1111. `seg`, `dp` and scanning continue unaffected.
- Raising `flash_en` therefore always starts with a visible half-period of exactly `BLINK_DIV` scan ticks.

**Output registering**
- `an`, `seg` and `dp` are registered from the next-state `idx` and shadow.
- The value shown always matches the current `idx` with no stale cycle.
- Exactly one `an` bit is low when visible: `an = ~(4'b0001 << idx)`.

**Reset**
- `reset` high on a clock edge sets `pre=0`, `idx=0`, `bcnt=0`, `phase=0` and all shadow registers to 0.
- Output reset values: `an=1111`, `seg=1111111`, `dp=1`, `frame_start=0`.
- Asserting `reset` mid-frame or mid-blink fully restarts operation. No partial state survives.

## Timing

**After reset release** (cycle 0 = first edge with reset low)
- `an=1110`, `seg=1000000`, `dp=1`.
- The shadow holds 0 until the first wrap.

**Digit dwell**
- Each digit is held for `SCAN_DIV` cycles. A full frame is `4*SCAN_DIV` cycles.

**Capture and frame start**
- The first capture occurs at cycle `4*SCAN_DIV-1`.
- The first `frame_start` is at cycle `4*SCAN_DIV`, which is also when the new digit-0 value first appears.

**Blink period**
- The full blink period is `2*BLINK_DIV*SCAN_DIV` cycles.

**Event interaction**
- `flash_en` falling takes effect on the next edge: `phase` goes to 0 and `an` is driven visible.
- A snapshot and a blink toggle on the same `scan_tick` are independent; both apply.

## Test plan

Bench parameters: `CLK_HZ=16`, `SCAN_HZ=4` (`SCAN_DIV=4`), `BLINK_HZ=1` (`BLINK_DIV=2`).

1. **Reset values.** Hold `reset` for 3 cycles with inputs 9,5,9,9 → during reset `an=1111`, `seg=1111111`, `dp=1`. After release `an=1110`, `seg=1000000` (shadow 0), then `an` steps through 1101, 1011, 0111 at 4-cycle intervals.
2. **Capture and decimal points.** Inputs m=1, st=2, so=3, t=4 → after the first `frame_start` (cycle 16), observe:
   - `an=1110` with `seg=0011001`, `dp=1`
   - `an=1101` with `seg=0110000`, `dp=0`
   - `an=1011` with `seg=0100100`, `dp=1`
   - `an=0111` with `seg=1111001`, `dp=0`
3. **No tearing.** Change `tenths_bcd` from 4 to 7 while `idx=2` → digit 0 still shows 4 for the rest of the frame. 7 (`seg=1111000`) appears only after the next `frame_start`.
4. **Invalid BCD.** `sec_ones_bcd=4'hC` → digit 1 shows `seg=0111111`, and other digits decode normally.
5. **Blink.** Raise `flash_en` at a `scan_tick` → display is visible for 8 cycles, then `an=1111` for 8 cycles, repeating. `seg` keeps stepping during the blank phase. Dropping `flash_en` while blank makes `an` visible on the next edge.
6. **Reset mid-blink.** Assert `reset` for one cycle with `flash_en` high, mid-frame and during the blank phase → outputs take their reset values. After release `idx=0`, the shadow is 0, and the display is visible for a full 8-cycle half-period.
